// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store definitions: size codes, ls_op bit
// positions and lane-offset helpers.
package lsu_ctrl_pkg;

    localparam logic [1:0] LS_BYTE = 2'b01;
    localparam logic [1:0] LS_HALF = 2'b10;
    localparam logic [1:0] LS_WORD = 2'b11;

    localparam int LS_EN = 3;
    localparam int LS_ST = 2;

    // Byte lane actually used: halves drop bit0, words use lane 0
    function automatic logic [1:0] ls_off(
        input logic [1:0] size,
        input logic [1:0] a
    );
        case (size)
            LS_BYTE: ls_off = a;
            LS_HALF: ls_off = {a[1], 1'b0};
            default: ls_off = 2'b00;
        endcase
    endfunction

    function automatic logic ls_misal(
        input logic [1:0] size,
        input logic [1:0] a
    );
        case (size)
            LS_HALF: ls_misal = a[0];
            LS_WORD: ls_misal = (a != 2'b00);
            default: ls_misal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory req/gnt/rvalid bus between the LSU (master)
// and the memory (slave).
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32
) ();

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be,
        output mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be,
        input  mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Store lane generation (be/wdata) and load extract/extend.
// Purely combinational; offsets arrive already size-aligned.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_sign,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [31:0] sh;

    // Store lanes: replicate data, enable the addressed bytes
    always_comb begin
        be    = 4'hF;
        wdata = st_data;
        case (st_size)
            LS_BYTE: begin
                be    = 4'b0001 << st_off;
                wdata = {4{st_data[7:0]}};
            end
            LS_HALF: begin
                be    = st_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign sh = rdata >> {ld_off, 3'b000};

    // Load extract: shift lane down, then zero/sign extend
    always_comb begin
        ld_data = rdata;
        case (ld_size)
            LS_BYTE:
                ld_data = {{24{ld_sign & sh[7]}}, sh[7:0]};
            LS_HALF:
                ld_data = {{16{ld_sign & sh[15]}}, sh[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: IDLE/REQ/WAIT over the data-memory bus.
// Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [3:0]        ls_op,
    input  logic              ls_sign,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    input  logic [RD_W-1:0]   ls_rd,
    input  logic              lsu_flush,
    output logic              lsu_stall,
    lsu_ctrl_if.master        mem,
    output logic              wb_vld,
    output logic [RD_W-1:0]   wb_rd,
    output logic [31:0]       wb_data
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              lsu_excp,
    output logic [ADDR_W-1:0] lsu_excp_addr
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state, nxt;
    logic            accept, misal;
    logic            cap_sign, kill;
    logic [1:0]      cap_size, cap_off, st_off;
    logic [RD_W-1:0] cap_rd;
    logic [3:0]      al_be;
    logic [31:0]     al_wdata, al_ld;

    assign st_off = ls_off(ls_op[1:0], ls_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misal = ls_misal(ls_op[1:0], ls_addr[1:0]);
`else
    assign misal = 1'b0;
`endif

    lsu_align u_align (
        .st_size (ls_op[1:0]),
        .st_off  (st_off),
        .st_data (ls_wdata),
        .ld_size (cap_size),
        .ld_off  (cap_off),
        .ld_sign (cap_sign),
        .rdata   (mem.mem_rdata),
        .be      (al_be),
        .wdata   (al_wdata),
        .ld_data (al_ld)
    );

    assign mem.mem_req = (state == REQ);
    assign lsu_stall   = (state != IDLE);

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else       state <= nxt;
    end

    // Next state: flush beats a same-cycle grant
    always_comb begin
        nxt    = state;
        accept = 1'b0;
        case (state)
            IDLE: begin
                if (ls_op[LS_EN] && !lsu_flush && !misal) begin
                    nxt    = REQ;
                    accept = 1'b1;
                end
            end
            REQ: begin
                if (lsu_flush)
                    nxt = IDLE;
                else if (mem.mem_gnt)
                    nxt = mem.mem_we ? IDLE : WAIT;
            end
            WAIT: begin
                if (mem.mem_rvalid) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Capture the op at accept; register the writeback
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            mem.mem_we    <= 1'b0;
            mem.mem_be    <= 4'h0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            cap_size      <= 2'b00;
            cap_off       <= 2'b00;
            cap_sign      <= 1'b0;
            cap_rd        <= '0;
            kill          <= 1'b0;
            wb_vld        <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
        end else begin
            if (accept) begin
                mem.mem_we    <= ls_op[LS_ST];
                mem.mem_be    <= ls_op[LS_ST] ? al_be : 4'hF;
                mem.mem_addr  <= {ls_addr[ADDR_W-1:2], 2'b00};
                mem.mem_wdata <= al_wdata;
                cap_size      <= ls_op[1:0];
                cap_off       <= st_off;
                cap_sign      <= ls_sign;
                cap_rd        <= ls_rd;
                kill          <= 1'b0;
            end
            if (state == WAIT && lsu_flush)
                kill <= 1'b1;
            wb_vld <= 1'b0;
            if (state == WAIT && mem.mem_rvalid) begin
                wb_vld  <= !(kill || lsu_flush);
                wb_rd   <= cap_rd;
                wb_data <= al_ld;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // One-cycle trap pulse for a misaligned accept attempt
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            lsu_excp      <= 1'b0;
            lsu_excp_addr <= '0;
        end else begin
            lsu_excp <= (state == IDLE) && ls_op[LS_EN]
                        && !lsu_flush && misal;
            if ((state == IDLE) && ls_op[LS_EN] && !lsu_flush && misal)
                lsu_excp_addr <= ls_addr;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table,
// hand-written corner sequences and randomized ops vs a model.
module tb_lsu_ctrl;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic [3:0]  ls_op;
    logic        ls_sign;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [4:0]  ls_rd;
    logic        lsu_flush;
    logic        lsu_stall;
    logic        wb_vld;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        gnt, rvalid;
    logic [31:0] rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        lsu_excp;
    logic [31:0] lsu_excp_addr;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    lsu_ctrl_if #(.ADDR_W(32)) bus ();

    assign bus.mem_gnt    = gnt;
    assign bus.mem_rvalid = rvalid;
    assign bus.mem_rdata  = rdata;

    lsu_ctrl #(.ADDR_W(32), .RD_W(5)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .ls_op     (ls_op),
        .ls_sign   (ls_sign),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_rd     (ls_rd),
        .lsu_flush (lsu_flush),
        .lsu_stall (lsu_stall),
        .mem       (bus),
        .wb_vld    (wb_vld),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .lsu_excp      (lsu_excp),
        .lsu_excp_addr (lsu_excp_addr)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        logic        st;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          gd;
        int          rvd;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_ld;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic st,
                       input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int gd,
                       input int rvd, input logic [31:0] e_addr,
                       input logic [3:0] e_be, input logic [31:0] e_wd,
                       input logic [31:0] e_ld);
        vec_t v;
        v = '{nm, st, size, sign, addr, wd, rd, gd, rvd,
              e_addr, e_be, e_wd, e_ld};
        vecs.push_back(v);
    endtask

    // Reference: byte-count arithmetic on the access
    function automatic void model(
        input  logic        st,
        input  logic [1:0]  size,
        input  logic        sign,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        input  logic [31:0] rd,
        output logic [31:0] m_addr,
        output logic [3:0]  m_be,
        output logic [31:0] m_wd,
        output logic [31:0] m_ld
    );
        int n;
        int lane;
        logic [63:0] mask, val;
        n = (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : 4;
        lane = int'(addr % 4);
        lane = lane - (lane % n);
        m_addr = addr & ~32'h3;
        m_be = st ? 4'(((1 << n) - 1) << lane) : 4'hF;
        for (int i = 0; i < 4; i++)
            m_wd[8*i +: 8] = wd[8*(i % n) +: 8];
        mask = (64'd1 << (8 * n)) - 64'd1;
        val  = ({32'd0, rd} >> (8 * lane)) & mask;
        if (sign && n < 4 && val[8*n-1])
            val = val | ~mask;
        m_ld = val[31:0];
    endfunction

    task automatic idle_in();
        ls_op     = 4'h0;
        ls_sign   = 1'b0;
        ls_addr   = '0;
        ls_wdata  = '0;
        ls_rd     = '0;
        lsu_flush = 1'b0;
        gnt       = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
    endtask

    task automatic issue(input logic st, input logic [1:0] size,
                         input logic sign, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        ls_op    = {1'b1, st, size};
        ls_sign  = sign;
        ls_addr  = addr;
        ls_wdata = wd;
        ls_rd    = rd;
        @(posedge CLK);
        #1;
        ls_op = 4'h0;
        ls_addr = $urandom;
        ls_wdata = $urandom;
    endtask

    // Full transaction with fixed grant/rvalid delays
    task automatic run_op(input vec_t v, input logic [4:0] rdi);
        issue(v.st, v.size, v.sign, v.addr, v.wd, rdi);
        for (int c = 0; c <= v.gd; c++) begin
            gnt = (c == v.gd);
            @(negedge CLK);
            chk({v.nm, " req"}, 32'(bus.mem_req), 32'd1);
            chk({v.nm, " addr"}, bus.mem_addr, v.e_addr);
            chk({v.nm, " be"}, 32'(bus.mem_be), 32'(v.e_be));
            chk({v.nm, " we"}, 32'(bus.mem_we), 32'(v.st));
            if (v.st)
                chk({v.nm, " wdata"}, bus.mem_wdata, v.e_wd);
            chk({v.nm, " stall"}, 32'(lsu_stall), 32'd1);
            @(posedge CLK);
            #1;
        end
        gnt = 1'b0;
        if (v.st) begin
            @(negedge CLK);
            chk({v.nm, " st idle"}, 32'(lsu_stall), 32'd0);
            chk({v.nm, " st req0"}, 32'(bus.mem_req), 32'd0);
        end else begin
            for (int c = 0; c <= v.rvd; c++) begin
                rvalid = (c == v.rvd);
                rdata  = (c == v.rvd) ? v.rd : $urandom;
                @(negedge CLK);
                chk({v.nm, " wait stall"}, 32'(lsu_stall), 32'd1);
                chk({v.nm, " wait req"}, 32'(bus.mem_req), 32'd0);
                chk({v.nm, " wait wb"}, 32'(wb_vld), 32'd0);
                @(posedge CLK);
                #1;
            end
            rvalid = 1'b0;
            rdata  = $urandom;
            @(negedge CLK);
            chk({v.nm, " wb_vld"}, 32'(wb_vld), 32'd1);
            chk({v.nm, " wb_data"}, wb_data, v.e_ld);
            chk({v.nm, " wb_rd"}, 32'(wb_rd), 32'(rdi));
            chk({v.nm, " wb stall"}, 32'(lsu_stall), 32'd0);
            @(posedge CLK);
            #1;
            @(negedge CLK);
            chk({v.nm, " wb pulse"}, 32'(wb_vld), 32'd0);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vec_t v;
        idle_in();
        RSTN = 1'b0;
        #3;
        chk("rst req", 32'(bus.mem_req), 32'd0);
        chk("rst we", 32'(bus.mem_we), 32'd0);
        chk("rst be", 32'(bus.mem_be), 32'd0);
        chk("rst addr", bus.mem_addr, 32'd0);
        chk("rst wdata", bus.mem_wdata, 32'd0);
        chk("rst wb_vld", 32'(wb_vld), 32'd0);
        chk("rst wb_rd", 32'(wb_rd), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst stall", 32'(lsu_stall), 32'd0);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        @(posedge CLK);
        #1;

        add("sw", 1, 2'b11, 0, 32'h104, 32'hDEADBEEF, 0, 0, 0,
            32'h104, 4'hF, 32'hDEADBEEF, 0);
        add("lb", 0, 2'b01, 1, 32'h203, 0, 32'h80123456, 0, 0,
            32'h200, 4'hF, 0, 32'hFFFFFF80);
        add("lhu", 0, 2'b10, 0, 32'h202, 0, 32'h80011234, 0, 0,
            32'h200, 4'hF, 0, 32'h00008001);
        add("sb", 1, 2'b01, 0, 32'h201, 32'h0000005A, 0, 0, 0,
            32'h200, 4'b0010, 32'h5A5A5A5A, 0);
        add("lw dly", 0, 2'b11, 0, 32'h300, 0, 32'h12345678, 3, 2,
            32'h300, 4'hF, 0, 32'h12345678);
        add("lh", 0, 2'b10, 1, 32'h206, 0, 32'h9ABC0000, 1, 1,
            32'h204, 4'hF, 0, 32'hFFFF9ABC);
        add("sh", 1, 2'b10, 0, 32'h20A, 32'h0000BEEF, 0, 2, 0,
            32'h208, 4'b1100, 32'hBEEFBEEF, 0);
        add("lbu", 0, 2'b01, 0, 32'h401, 0, 32'h0000F300, 0, 0,
            32'h400, 4'hF, 0, 32'h000000F3);
`ifndef LSU_MISALIGN_TRAP_EN
        add("lw mis", 0, 2'b11, 0, 32'h102, 0, 32'hCAFEF00D, 0, 0,
            32'h100, 4'hF, 0, 32'hCAFEF00D);
        add("sh mis", 1, 2'b10, 0, 32'h303, 32'h00001234, 0, 0, 0,
            32'h300, 4'b1100, 32'h12341234, 0);
`endif
        foreach (vecs[i])
            run_op(vecs[i], 5'(i + 1));

        // Flush in IDLE blocks accept
        lsu_flush = 1'b1;
        issue(0, 2'b11, 0, 32'h500, 0, 5'd3);
        lsu_flush = 1'b0;
        @(negedge CLK);
        chk("flush idle req", 32'(bus.mem_req), 32'd0);
        chk("flush idle stall", 32'(lsu_stall), 32'd0);
        @(posedge CLK);
        #1;

        // Flush in REQ with same-cycle grant; stray rvalid ignored
        issue(0, 2'b11, 0, 32'h600, 0, 5'd4);
        lsu_flush = 1'b1;
        gnt = 1'b1;
        @(negedge CLK);
        chk("flush req req", 32'(bus.mem_req), 32'd1);
        @(posedge CLK);
        #1;
        lsu_flush = 1'b0;
        gnt = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h11111111;
        @(negedge CLK);
        chk("flush req drop", 32'(bus.mem_req), 32'd0);
        chk("flush req stall", 32'(lsu_stall), 32'd0);
        @(posedge CLK);
        #1;
        rvalid = 1'b0;
        gnt = 1'b1;
        @(negedge CLK);
        chk("flush req wb", 32'(wb_vld), 32'd0);
        chk("stray gnt req", 32'(bus.mem_req), 32'd0);
        @(posedge CLK);
        #1;
        gnt = 1'b0;
        @(negedge CLK);
        chk("stray gnt stall", 32'(lsu_stall), 32'd0);
        @(posedge CLK);
        #1;

        // Flush in WAIT: response drained, writeback suppressed
        issue(0, 2'b11, 0, 32'h700, 0, 5'd5);
        gnt = 1'b1;
        @(posedge CLK);
        #1;
        gnt = 1'b0;
        lsu_flush = 1'b1;
        @(negedge CLK);
        chk("flush wait stall", 32'(lsu_stall), 32'd1);
        @(posedge CLK);
        #1;
        lsu_flush = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h22222222;
        @(posedge CLK);
        #1;
        rvalid = 1'b0;
        @(negedge CLK);
        chk("flush wait wb", 32'(wb_vld), 32'd0);
        chk("flush wait idle", 32'(lsu_stall), 32'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("flush wait wb2", 32'(wb_vld), 32'd0);
        @(posedge CLK);
        #1;

        // Reset mid-op in WAIT; late response ignored
        issue(0, 2'b11, 0, 32'h800, 0, 5'd6);
        gnt = 1'b1;
        @(posedge CLK);
        #1;
        gnt = 1'b0;
        #2;
        RSTN = 1'b0;
        #1;
        chk("midrst stall", 32'(lsu_stall), 32'd0);
        chk("midrst req", 32'(bus.mem_req), 32'd0);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        rvalid = 1'b1;
        rdata = 32'h33333333;
        @(posedge CLK);
        #1;
        rvalid = 1'b0;
        @(negedge CLK);
        chk("midrst wb", 32'(wb_vld), 32'd0);
        chk("midrst idle", 32'(lsu_stall), 32'd0);
        @(posedge CLK);
        #1;

`ifdef LSU_MISALIGN_TRAP_EN
        issue(0, 2'b11, 0, 32'h102, 0, 5'd7);
        @(negedge CLK);
        chk("trap excp", 32'(lsu_excp), 32'd1);
        chk("trap addr", lsu_excp_addr, 32'h102);
        chk("trap req", 32'(bus.mem_req), 32'd0);
        chk("trap stall", 32'(lsu_stall), 32'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("trap pulse", 32'(lsu_excp), 32'd0);
        chk("trap wb", 32'(wb_vld), 32'd0);
        @(posedge CLK);
        #1;
`endif

        // Randomized ops vs reference model
        for (int k = 0; k < 60; k++) begin
            v.nm   = "rnd";
            v.st   = 1'($urandom);
            v.size = 2'($urandom_range(1, 3));
            v.sign = 1'($urandom);
            v.addr = $urandom & 32'h0000FFFF;
`ifdef LSU_MISALIGN_TRAP_EN
            if (v.size == 2'd2) v.addr[0] = 1'b0;
            if (v.size == 2'd3) v.addr[1:0] = 2'b00;
`endif
            v.wd  = $urandom;
            v.rd  = $urandom;
            v.gd  = $urandom_range(0, 3);
            v.rvd = $urandom_range(0, 3);
            model(v.st, v.size, v.sign, v.addr, v.wd, v.rd,
                  v.e_addr, v.e_be, v.e_wd, v.e_ld);
            run_op(v, 5'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
